// File: rtl/flags_controller_if.sv
// Bundle of the flags controller's request and status signals.
// Signal prefixes are from the controller's point of view: i_* flow into
// the controller, o_* flow out of it.
interface flags_controller_if #(
  parameter int P_FLAG_WIDTH = 5,
  parameter int P_PTR_WIDTH  = 3
);

  logic                    i_alu_valid;
  logic [P_FLAG_WIDTH-1:0] i_alu_mask;
  logic [P_FLAG_WIDTH-1:0] i_alu_flags;
  logic                    i_wr_valid;
  logic [P_FLAG_WIDTH-1:0] i_wr_flags;
  logic                    i_save;
  logic                    i_restore;
  logic [3:0]              i_cond;
  logic                    i_err_clr;

  logic [P_FLAG_WIDTH-1:0] o_flags;
  logic                    o_cond_true;
  logic [P_PTR_WIDTH-1:0]  o_depth;
  logic                    o_stack_full;
  logic                    o_stack_empty;
  logic                    o_err;

  // The side that issues requests (ALU, decoder, control unit).
  modport master (
    output i_alu_valid, i_alu_mask, i_alu_flags,
    output i_wr_valid, i_wr_flags,
    output i_save, i_restore, i_cond, i_err_clr,
    input  o_flags, o_cond_true, o_depth,
    input  o_stack_full, o_stack_empty, o_err
  );

  // The flags controller itself.
  modport slave (
    input  i_alu_valid, i_alu_mask, i_alu_flags,
    input  i_wr_valid, i_wr_flags,
    input  i_save, i_restore, i_cond, i_err_clr,
    output o_flags, o_cond_true, o_depth,
    output o_stack_full, o_stack_empty, o_err
  );

endinterface

// File: rtl/flags_controller.sv
// Processor status flags register with a small interrupt shadow stack.
// Flag bit map: [0]=C, [1]=L, [2]=F, [3]=Z, [4]=N.
// Arbitrates restore / software write / ALU update into the flags, keeps a
// LIFO of saved flags for nested interrupts, flags misuse of that stack in a
// sticky error, and evaluates branch condition codes against the flags.
module flags_controller #(
  parameter int P_FLAG_WIDTH = 5,
  parameter int P_DEPTH      = 4,
  parameter int P_PTR_WIDTH  = 3
) (
  input  logic                  i_clk,
  input  logic                  i_nreset,
  flags_controller_if.slave     bus
);

  localparam int L_IDX_WIDTH = $clog2(P_DEPTH);
  localparam logic [P_PTR_WIDTH-1:0] L_FULL_COUNT = P_PTR_WIDTH'(P_DEPTH);

  // Flag bit positions, used by the condition decoder.
  localparam int L_BIT_C = 0;
  localparam int L_BIT_L = 1;
  localparam int L_BIT_F = 2;
  localparam int L_BIT_Z = 3;
  localparam int L_BIT_N = 4;

  logic [P_FLAG_WIDTH-1:0] r_flags;
  logic [P_PTR_WIDTH-1:0]  r_depth;
  logic                    r_err;
  logic [P_FLAG_WIDTH-1:0] r_stack [P_DEPTH];

  logic                    w_full;
  logic                    w_empty;
  logic                    w_conflict;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_err_event;
  logic [L_IDX_WIDTH-1:0]  w_push_idx;
  logic [L_IDX_WIDTH-1:0]  w_top_idx;
  logic [P_FLAG_WIDTH-1:0] w_top_flags;
  logic [P_FLAG_WIDTH-1:0] w_alu_merged;
  logic [P_FLAG_WIDTH-1:0] w_next_flags;
  logic [P_PTR_WIDTH-1:0]  w_next_depth;
  logic                    w_cond_true;

  assign w_full  = (r_depth == L_FULL_COUNT);
  assign w_empty = (r_depth == '0);

  // The next free slot is the current depth; the top entry sits one below.
  // When full the low index bits wrap to 0, which is never used for a push.
  assign w_push_idx  = r_depth[L_IDX_WIDTH-1:0];
  assign w_top_idx   = r_depth[L_IDX_WIDTH-1:0] - 1'b1;
  assign w_top_flags = r_stack[w_top_idx];

  // Decide whether this cycle legally pushes or pops, and whether the stack
  // request is an error (simultaneous save/restore, overflow, underflow).
  always_comb begin
    w_conflict  = bus.i_save & bus.i_restore;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_err_event = 1'b0;
    if (w_conflict) begin
      w_err_event = 1'b1;
    end else if (bus.i_save) begin
      if (w_full) begin
        w_err_event = 1'b1;
      end else begin
        w_push = 1'b1;
      end
    end else if (bus.i_restore) begin
      if (w_empty) begin
        w_err_event = 1'b1;
      end else begin
        w_pop = 1'b1;
      end
    end
  end

  // Select the next flags value: restore beats software write beats ALU.
  always_comb begin
    w_alu_merged = (r_flags & ~bus.i_alu_mask) | (bus.i_alu_flags & bus.i_alu_mask);
    w_next_flags = r_flags;
    if (w_pop) begin
      w_next_flags = w_top_flags;
    end else if (bus.i_wr_valid) begin
      w_next_flags = bus.i_wr_flags;
    end else if (bus.i_alu_valid) begin
      w_next_flags = w_alu_merged;
    end
  end

  // Depth only moves on a legal push or pop, so it can never wrap.
  always_comb begin
    w_next_depth = r_depth;
    if (w_push) begin
      w_next_depth = r_depth + 1'b1;
    end else if (w_pop) begin
      w_next_depth = r_depth - 1'b1;
    end
  end

  // Flags and depth registers.
  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      r_flags <= '0;
      r_depth <= '0;
    end else begin
      r_flags <= w_next_flags;
      r_depth <= w_next_depth;
    end
  end

  // Shadow stack storage; a push captures the flags as they were before
  // this edge, regardless of any write landing in the flags register.
  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      for (int i = 0; i < P_DEPTH; i++) begin
        r_stack[i] <= '0;
      end
    end else if (w_push) begin
      r_stack[w_push_idx] <= r_flags;
    end
  end

  // Sticky error: a new error outranks a simultaneous clear.
  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      r_err <= 1'b0;
    end else if (w_err_event) begin
      r_err <= 1'b1;
    end else if (bus.i_err_clr) begin
      r_err <= 1'b0;
    end
  end

  // Branch condition decode against the registered flags.
  always_comb begin
    w_cond_true = 1'b0;
    case (bus.i_cond)
      4'h0:    w_cond_true =  r_flags[L_BIT_Z];
      4'h1:    w_cond_true = ~r_flags[L_BIT_Z];
      4'h2:    w_cond_true =  r_flags[L_BIT_C];
      4'h3:    w_cond_true = ~r_flags[L_BIT_C];
      4'h4:    w_cond_true =  r_flags[L_BIT_L];
      4'h5:    w_cond_true = ~r_flags[L_BIT_L];
      4'h6:    w_cond_true =  r_flags[L_BIT_N];
      4'h7:    w_cond_true = ~r_flags[L_BIT_N];
      4'h8:    w_cond_true =  r_flags[L_BIT_F];
      4'h9:    w_cond_true = ~r_flags[L_BIT_F];
      4'hA:    w_cond_true = ~r_flags[L_BIT_L] & ~r_flags[L_BIT_Z];
      4'hB:    w_cond_true =  r_flags[L_BIT_L] |  r_flags[L_BIT_Z];
      4'hC:    w_cond_true = ~r_flags[L_BIT_N] & ~r_flags[L_BIT_Z];
      4'hD:    w_cond_true =  r_flags[L_BIT_N] |  r_flags[L_BIT_Z];
      4'hE:    w_cond_true = 1'b1;
      default: w_cond_true = 1'b0;
    endcase
  end

  assign bus.o_flags       = r_flags;
  assign bus.o_cond_true   = w_cond_true;
  assign bus.o_depth       = r_depth;
  assign bus.o_stack_full  = w_full;
  assign bus.o_stack_empty = w_empty;
  assign bus.o_err         = r_err;

endmodule

// File: tb/tb_flags_controller.sv
// Directed testbench for flags_controller with hand-computed expectations.
module tb_flags_controller;

  logic clk;
  logic rst_n;
  int   checkCount;
  int   errorCount;

  flags_controller_if #(.P_FLAG_WIDTH(5), .P_PTR_WIDTH(3)) bus ();

  flags_controller #(
    .P_FLAG_WIDTH(5),
    .P_DEPTH(4),
    .P_PTR_WIDTH(3)
  ) dut (
    .i_clk(clk),
    .i_nreset(rst_n),
    .bus(bus.slave)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expected value and count it.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of requests, let the edge take them, then idle inputs.
  task automatic applyStimulus(input logic aluV, input logic [4:0] mask, input logic [4:0] aluF,
                               input logic wrV, input logic [4:0] wrF,
                               input logic save, input logic restore, input logic errClr);
    bus.i_alu_valid = aluV;
    bus.i_alu_mask  = mask;
    bus.i_alu_flags = aluF;
    bus.i_wr_valid  = wrV;
    bus.i_wr_flags  = wrF;
    bus.i_save      = save;
    bus.i_restore   = restore;
    bus.i_err_clr   = errClr;
    @(posedge clk);
    #1;
    bus.i_alu_valid = 1'b0;
    bus.i_alu_mask  = '0;
    bus.i_alu_flags = '0;
    bus.i_wr_valid  = 1'b0;
    bus.i_wr_flags  = '0;
    bus.i_save      = 1'b0;
    bus.i_restore   = 1'b0;
    bus.i_err_clr   = 1'b0;
    #1;
  endtask

  // Sweep all sixteen condition codes against a 16-bit truth vector.
  task automatic sweepCond(input logic [4:0] flagsVal, input logic [15:0] truth);
    applyStimulus(1'b0, 5'h00, 5'h00, 1'b1, flagsVal, 1'b0, 1'b0, 1'b0);
    checkOutput("sweep_flags", bus.o_flags, flagsVal);
    for (int c = 0; c < 16; c++) begin
      bus.i_cond = 4'(c);
      #1;
      checkOutput($sformatf("cond_%0h_flags_%05b", c, flagsVal), bus.o_cond_true, truth[c]);
    end
    bus.i_cond = 4'h0;
  endtask

  logic [4:0]  expPop [4];
  logic [15:0] sweepTruth [5];
  logic [4:0]  sweepFlags [5];

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst_n = 1'b0;
    bus.i_alu_valid = 1'b0;
    bus.i_alu_mask  = '0;
    bus.i_alu_flags = '0;
    bus.i_wr_valid  = 1'b0;
    bus.i_wr_flags  = '0;
    bus.i_save      = 1'b0;
    bus.i_restore   = 1'b0;
    bus.i_cond      = 4'h0;
    bus.i_err_clr   = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    $display("[TB] reset state");
    checkOutput("rst_flags", bus.o_flags, 5'b00000);
    checkOutput("rst_depth", bus.o_depth, 3'd0);
    checkOutput("rst_empty", bus.o_stack_empty, 1'b1);
    checkOutput("rst_full", bus.o_stack_full, 1'b0);
    checkOutput("rst_err", bus.o_err, 1'b0);
    checkOutput("rst_cond_eq", bus.o_cond_true, 1'b0);

    $display("[TB] masked ALU update");
    applyStimulus(1'b1, 5'b01000, 5'b11111, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("alu_mask_z", bus.o_flags, 5'b01000);
    bus.i_cond = 4'h0; #1;
    checkOutput("alu_cond_eq", bus.o_cond_true, 1'b1);
    bus.i_cond = 4'h1; #1;
    checkOutput("alu_cond_ne", bus.o_cond_true, 1'b0);
    bus.i_cond = 4'h0;
    applyStimulus(1'b1, 5'b00000, 5'b10111, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("alu_mask_zero", bus.o_flags, 5'b01000);
    applyStimulus(1'b1, 5'b10001, 5'b10110, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("alu_mask_nc", bus.o_flags, 5'b11000);

    $display("[TB] write beats ALU");
    applyStimulus(1'b1, 5'b11111, 5'b00000, 1'b1, 5'b00101, 1'b0, 1'b0, 1'b0);
    checkOutput("wr_over_alu", bus.o_flags, 5'b00101);

    $display("[TB] save with same-cycle ALU write, then restore");
    applyStimulus(1'b0, 5'h00, 5'h00, 1'b1, 5'b00010, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 5'b01000, 5'b01000, 1'b0, 5'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("save_flags", bus.o_flags, 5'b01010);
    checkOutput("save_depth", bus.o_depth, 3'd1);
    checkOutput("save_empty", bus.o_stack_empty, 1'b0);
    applyStimulus(1'b0, 5'h00, 5'h00, 1'b0, 5'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("restore_flags", bus.o_flags, 5'b00010);
    checkOutput("restore_depth", bus.o_depth, 3'd0);
    checkOutput("restore_empty", bus.o_stack_empty, 1'b1);
    checkOutput("restore_err", bus.o_err, 1'b0);

    $display("[TB] overflow and LIFO order");
    applyStimulus(1'b0, 5'h00, 5'h00, 1'b1, 5'b00001, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'h00, 5'h00, 1'b1, 5'b00010, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'h00, 5'h00, 1'b1, 5'b00011, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'h00, 5'h00, 1'b1, 5'b00100, 1'b1, 1'b0, 1'b0);
    checkOutput("ovf_err_before", bus.o_err, 1'b0);
    applyStimulus(1'b0, 5'h00, 5'h00, 1'b1, 5'b00101, 1'b1, 1'b0, 1'b0);
    checkOutput("ovf_full4", bus.o_stack_full, 1'b1);
    applyStimulus(1'b0, 5'h00, 5'h00, 1'b1, 5'b00110, 1'b1, 1'b0, 1'b0);
    checkOutput("ovf_depth", bus.o_depth, 3'd4);
    checkOutput("ovf_full", bus.o_stack_full, 1'b1);
    checkOutput("ovf_err", bus.o_err, 1'b1);
    checkOutput("ovf_flags", bus.o_flags, 5'b00110);
    expPop[0] = 5'b00100;
    expPop[1] = 5'b00011;
    expPop[2] = 5'b00010;
    expPop[3] = 5'b00001;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 5'h00, 5'h00, 1'b0, 5'h00, 1'b0, 1'b1, 1'b0);
      checkOutput($sformatf("lifo_pop%0d", k), bus.o_flags, expPop[k]);
      checkOutput($sformatf("lifo_depth%0d", k), bus.o_depth, 3'(3 - k));
    end
    checkOutput("lifo_empty", bus.o_stack_empty, 1'b1);
    applyStimulus(1'b0, 5'h00, 5'h00, 1'b0, 5'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("udf_flags", bus.o_flags, 5'b00001);
    checkOutput("udf_depth", bus.o_depth, 3'd0);
    checkOutput("udf_err", bus.o_err, 1'b1);
    applyStimulus(1'b0, 5'h00, 5'h00, 1'b0, 5'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("err_clr", bus.o_err, 1'b0);

    $display("[TB] underflow with write still applies");
    applyStimulus(1'b0, 5'h00, 5'h00, 1'b1, 5'b10001, 1'b0, 1'b1, 1'b0);
    checkOutput("udf_wr_flags", bus.o_flags, 5'b10001);
    checkOutput("udf_wr_err", bus.o_err, 1'b1);
    applyStimulus(1'b0, 5'h00, 5'h00, 1'b0, 5'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("err_clr2", bus.o_err, 1'b0);

    $display("[TB] save/restore conflict at depth 2");
    applyStimulus(1'b0, 5'h00, 5'h00, 1'b1, 5'b01100, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'h00, 5'h00, 1'b1, 5'b10100, 1'b1, 1'b0, 1'b0);
    checkOutput("conf_pre_depth", bus.o_depth, 3'd2);
    applyStimulus(1'b0, 5'h00, 5'h00, 1'b0, 5'h00, 1'b1, 1'b1, 1'b0);
    checkOutput("conf_depth", bus.o_depth, 3'd2);
    checkOutput("conf_err", bus.o_err, 1'b1);
    checkOutput("conf_flags", bus.o_flags, 5'b10100);
    applyStimulus(1'b0, 5'h00, 5'h00, 1'b0, 5'h00, 1'b1, 1'b1, 1'b1);
    checkOutput("err_vs_clr", bus.o_err, 1'b1);
    applyStimulus(1'b0, 5'h00, 5'h00, 1'b0, 5'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("err_clr3", bus.o_err, 1'b0);

    $display("[TB] restore beats write");
    applyStimulus(1'b1, 5'b11111, 5'b00111, 1'b1, 5'b11111, 1'b0, 1'b1, 1'b0);
    checkOutput("rest_over_wr", bus.o_flags, 5'b01100);
    checkOutput("rest_over_wr_depth", bus.o_depth, 3'd1);

    $display("[TB] condition sweeps");
    sweepFlags[0] = 5'b00000; sweepTruth[0] = 16'h56AA;
    sweepFlags[1] = 5'b11111; sweepTruth[1] = 16'h6955;
    sweepFlags[2] = 5'b00010; sweepTruth[2] = 16'h5A9A;
    sweepFlags[3] = 5'b10000; sweepTruth[3] = 16'h666A;
    sweepFlags[4] = 5'b00001; sweepTruth[4] = 16'h56A6;
    for (int p = 0; p < 5; p++) begin
      sweepCond(sweepFlags[p], sweepTruth[p]);
    end

    $display("[TB] asynchronous reset mid-operation");
    applyStimulus(1'b0, 5'h00, 5'h00, 1'b1, 5'b11011, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'h00, 5'h00, 1'b0, 5'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("pre_rst_depth", bus.o_depth, 3'd3);
    checkOutput("pre_rst_flags", bus.o_flags, 5'b11011);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_depth", bus.o_depth, 3'd0);
    checkOutput("async_rst_flags", bus.o_flags, 5'b00000);
    checkOutput("async_rst_empty", bus.o_stack_empty, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    applyStimulus(1'b0, 5'h00, 5'h00, 1'b0, 5'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("post_rst_restore_flags", bus.o_flags, 5'b00000);
    checkOutput("post_rst_restore_err", bus.o_err, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
